// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment scanner.
// Keeps a shadow and an active character store; the shadow is copied into the
// active store only on a frame-start tick, so a frame never shows a mix.
// Optional per-digit blinking is compiled in with `define SEG_DISP_BLINK_EN.
module seg_scan_display #(
  parameter  int DIGITS       = 8,
  parameter  int CHAR_W       = 6,
  parameter  int SCAN_DIV     = 100000,
  parameter  int BLINK_FRAMES = 64,
  localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int ND_W         = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              wr_dp,
  input  logic              commit,
  input  logic [ND_W-1:0]   num_digits,
  input  logic [DIGITS-1:0] blink_mask,
  output logic              commit_done,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg_out
);

  // Handshake: wr_en and commit are single-cycle strobes with no backpressure.
  // wr_en lands in the shadow at the sampling edge; commit only raises a
  // pending flag. The copy happens on the next frame-start tick and
  // commit_done is high for exactly the cycle after that copying edge.

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [ND_W-1:0]  ND_MAX  = ND_W'(DIGITS);

  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic              tick;
  logic              frame_start;
  logic              copy;
  logic              wr_ok;
  logic              pending_q;
  logic              pending_d;
  logic [ND_W-1:0]   nd_q;
  logic [CHAR_W-1:0] sh_char_q  [DIGITS];
  logic [CHAR_W-1:0] act_char_q [DIGITS];
  logic [DIGITS-1:0] sh_dp_q;
  logic [DIGITS-1:0] act_dp_q;
  logic              commit_done_q;
  logic [DIGITS-1:0] seg_en_q;
  logic [DIGITS-1:0] seg_en_d;
  logic [7:0]        seg_out_q;
  logic [7:0]        seg_out_d;
  logic              blink_off;

  assign tick        = (cnt_q == CNT_MAX);
  assign frame_start = tick && (scan_idx_q == IDX_MAX);
  assign copy        = frame_start && pending_q;
  assign wr_ok       = wr_en && ({1'b0, wr_idx} < ND_MAX);
  // A commit seen on the copying edge itself waits for the following frame.
  assign pending_d   = copy ? commit : (pending_q | commit);

  // Glyph table, bit order {g,f,e,d,c,b,a}, active-high before inversion.
  function automatic logic [6:0] glyph(input logic [CHAR_W-1:0] code);
    case (int'(code))
      0:  glyph = 7'h3F;  1:  glyph = 7'h06;  2:  glyph = 7'h5B;  3:  glyph = 7'h4F;
      4:  glyph = 7'h66;  5:  glyph = 7'h6D;  6:  glyph = 7'h7D;  7:  glyph = 7'h07;
      8:  glyph = 7'h7F;  9:  glyph = 7'h6F;  10: glyph = 7'h77;  11: glyph = 7'h7C;
      12: glyph = 7'h39;  13: glyph = 7'h5E;  14: glyph = 7'h79;  15: glyph = 7'h71;
      16: glyph = 7'h3D;  17: glyph = 7'h76;  18: glyph = 7'h30;  19: glyph = 7'h1E;
      20: glyph = 7'h75;  21: glyph = 7'h38;  22: glyph = 7'h55;  23: glyph = 7'h54;
      24: glyph = 7'h5C;  25: glyph = 7'h73;  26: glyph = 7'h67;  27: glyph = 7'h50;
      28: glyph = 7'h6D;  29: glyph = 7'h78;  30: glyph = 7'h3E;  31: glyph = 7'h1C;
      32: glyph = 7'h2A;  33: glyph = 7'h76;  34: glyph = 7'h6E;  35: glyph = 7'h5B;
      36: glyph = 7'h40;  37: glyph = 7'h08;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Prescaler and digit-slot counter; the DIGITS-1 -> 0 wrap is the frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      scan_idx_q <= '0;
    end else if (tick) begin
      cnt_q      <= '0;
      scan_idx_q <= (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

  // Double-buffered store, commit tracking and per-slot num_digits sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        sh_char_q[i]  <= '0;
        act_char_q[i] <= '0;
      end
      sh_dp_q       <= '0;
      act_dp_q      <= '0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      nd_q          <= ND_MAX;
    end else begin
      // The active store takes the shadow as it stood before this edge's write.
      if (copy) begin
        act_char_q <= sh_char_q;
        act_dp_q   <= sh_dp_q;
      end
      if (wr_ok) begin
        sh_char_q[wr_idx] <= wr_char;
        sh_dp_q[wr_idx]   <= wr_dp;
      end
      pending_q     <= pending_d;
      commit_done_q <= copy;
      if (tick) begin
        nd_q <= (num_digits > ND_MAX) ? ND_MAX : num_digits;
      end
    end
  end

`ifdef SEG_DISP_BLINK_EN
  localparam int              FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q;
  logic            phase_on_q;

  // Blink phase flips after every BLINK_FRAMES frame starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt_q == FC_MAX) begin
        frame_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FC_W'(1);
      end
    end
  end

  assign blink_off = !phase_on_q && blink_mask[scan_idx_q];
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES > 0);
  assign blink_off    = 1'b0;
`endif

  // Next digit enable and segment pattern for the current slot.
  always_comb begin
    seg_en_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1 - int'(scan_idx_q)) seg_en_d[i] = 1'b0;
    end
    seg_out_d = 8'hFF;
    if (({1'b0, scan_idx_q} < nd_q) && !blink_off) begin
      seg_out_d = {~act_dp_q[scan_idx_q], ~glyph(act_char_q[scan_idx_q])};
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_en_q  <= '1;
      seg_out_q <= 8'hFF;
    end else begin
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign commit_done = commit_done_q;
  assign seg_en      = seg_en_q;
  assign seg_out     = seg_out_q;

endmodule
